// File: rtl/pe_sched.sv
// Row scheduler for one attention PE: clear, load Q, stream K/V, wait for output.
// Optional stall counter enabled by defining PE_SCHED_PERF_EN.
module pe_sched #(
  parameter int Q_ROWS  = 64,
  parameter int KV_ROWS = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W:0]   q_len,
  input  logic [IDX_W:0]   kv_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             q_src_vld,
  output logic             q_src_rdy,
  input  logic             kv_src_vld,
  output logic             kv_src_rdy,
  output logic [IDX_W-1:0] q_idx,
  output logic [IDX_W-1:0] kv_idx,
  output logic             pe_q_vld,
  input  logic             pe_q_rdy,
  output logic             pe_k_vld,
  output logic             pe_v_vld,
  input  logic             pe_k_rdy,
  input  logic             pe_v_rdy,
  output logic             pe_row_start,
  input  logic             pe_o_vld,
  input  logic             o_sram_rdy,
  output logic             o_wr_en,
  output logic [IDX_W-1:0] o_wr_addr,
  output logic [31:0]      stall_cnt
);
  localparam int LW = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD_Q, STREAM_KV, WAIT_O, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    qlen_q, qlen_d;
  logic [LW-1:0]    kvlen_q, kvlen_d;
  logic [IDX_W-1:0] qidx_q, qidx_d;
  logic [IDX_W-1:0] kvidx_q, kvidx_d;
  logic             err_q, err_d;
  logic             done_q;
  logic [LW-1:0]    q_cl, kv_cl;
  logic             o_fire, kv_last, q_last;

  always_comb begin
    q_cl  = (q_len > LW'(Q_ROWS)) ? LW'(Q_ROWS) : q_len;
    kv_cl = (kv_len > LW'(KV_ROWS)) ? LW'(KV_ROWS) : kv_len;
    o_fire  = pe_o_vld & o_sram_rdy;
    kv_last = ({1'b0, kvidx_q} == (kvlen_q - LW'(1)));
    q_last  = ({1'b0, qidx_q} == (qlen_q - LW'(1)));
  end

  always_comb begin
    state_d      = state_q;
    qlen_d       = qlen_q;
    kvlen_d      = kvlen_q;
    qidx_d       = qidx_q;
    kvidx_d      = kvidx_q;
    err_d        = err_q;
    pe_row_start = 1'b0;
    pe_q_vld     = 1'b0;
    q_src_rdy    = 1'b0;
    pe_k_vld     = 1'b0;
    pe_v_vld     = 1'b0;
    kv_src_rdy   = 1'b0;
    o_wr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          qlen_d  = q_cl;
          kvlen_d = kv_cl;
          qidx_d  = '0;
          err_d   = 1'b0;
          state_d = (q_cl == '0 || kv_cl == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        pe_row_start = 1'b1;
        kvidx_d      = '0;
        state_d      = LOAD_Q;
      end
      LOAD_Q: begin
        pe_q_vld  = q_src_vld;
        q_src_rdy = pe_q_rdy;
        if (q_src_vld && pe_q_rdy) state_d = STREAM_KV;
      end
      STREAM_KV: begin
        pe_k_vld   = kv_src_vld;
        pe_v_vld   = kv_src_vld;
        kv_src_rdy = pe_k_rdy & pe_v_rdy;
        if (kv_src_vld && pe_k_rdy && pe_v_rdy) begin
          kvidx_d = kvidx_q + 1'b1;
          if (kv_last) state_d = WAIT_O;
        end
      end
      WAIT_O: begin
        if (o_fire) begin
          o_wr_en = 1'b1;
          if (q_last) begin
            state_d = DONE;
          end else begin
            qidx_d  = qidx_q + 1'b1;
            state_d = CLEAR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A stray output beat is flagged but never written to OSRAM.
    if (o_fire && state_q != WAIT_O) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      qlen_q  <= '0;
      kvlen_q <= '0;
      qidx_q  <= '0;
      kvidx_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qlen_q  <= qlen_d;
      kvlen_q <= kvlen_d;
      qidx_q  <= qidx_d;
      kvidx_q <= kvidx_d;
      err_q   <= err_d;
      done_q  <= (state_q == DONE);
    end
  end

  assign busy      = (state_q != IDLE) | done_q;
  assign done      = done_q;
  assign err       = err_q;
  assign q_idx     = qidx_q;
  assign kv_idx    = kvidx_q;
  assign o_wr_addr = o_wr_en ? qidx_q : '0;

`ifdef PE_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (state_q == STREAM_KV && kv_src_vld &&
                 !(pe_k_rdy && pe_v_rdy) && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_sched.sv
// Directed self-checking bench for pe_sched.
// Table of job vectors plus hand sequences for timing and corner cases.
module tb_pe_sched;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [IW:0]   q_len, kv_len;
  logic          busy, done, err;
  logic          q_src_vld, q_src_rdy, kv_src_vld, kv_src_rdy;
  logic [IW-1:0] q_idx, kv_idx, o_wr_addr;
  logic          pe_q_vld, pe_q_rdy, pe_k_vld, pe_v_vld;
  logic          pe_k_rdy, pe_v_rdy, pe_row_start;
  logic          pe_o_vld, o_sram_rdy, o_wr_en;
  logic [31:0]   stall_cnt;

  always #5 clk = ~clk;

  pe_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .q_len(q_len), .kv_len(kv_len),
    .busy(busy), .done(done), .err(err),
    .q_src_vld(q_src_vld), .q_src_rdy(q_src_rdy),
    .kv_src_vld(kv_src_vld), .kv_src_rdy(kv_src_rdy),
    .q_idx(q_idx), .kv_idx(kv_idx),
    .pe_q_vld(pe_q_vld), .pe_q_rdy(pe_q_rdy),
    .pe_k_vld(pe_k_vld), .pe_v_vld(pe_v_vld),
    .pe_k_rdy(pe_k_rdy), .pe_v_rdy(pe_v_rdy),
    .pe_row_start(pe_row_start),
    .pe_o_vld(pe_o_vld), .o_sram_rdy(o_sram_rdy),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .stall_cnt(stall_cnt)
  );

  int errors = 0;
  int checks = 0;
  int q_fires, kv_fires, row_starts, writes, done_cnt, kv_split;
  int kv_seq[$];
  int addr_seq[$];
  int exp_kvl = 1;
  bit kv_last_seen = 0;
  bit auto_o = 1;
  int lat_cnt = 0;

`ifdef PE_SCHED_PERF_EN
  localparam int EXP_STALL = 5;
`else
  localparam int EXP_STALL = 0;
`endif

  typedef struct {
    int ql; int kl; int poke;
    int rs; int qf; int kf; int wr;
  } vec_t;
  vec_t vt[7];

  always @(negedge clk) begin
    if (pe_q_vld && pe_q_rdy) q_fires++;
    if (pe_k_vld != pe_v_vld) kv_split++;
    if (pe_k_vld && pe_k_rdy && pe_v_rdy) begin
      kv_fires++;
      kv_seq.push_back(int'(kv_idx));
      if (int'(kv_idx) == exp_kvl - 1) kv_last_seen = 1;
    end
    if (pe_row_start) row_starts++;
    if (o_wr_en) begin
      writes++;
      addr_seq.push_back(int'(o_wr_addr));
    end
    if (done) done_cnt++;
  end

  // PE output model: result ready 4 cycles after the last K/V beat.
  always @(posedge clk) begin
    #2;
    if (auto_o) begin
      pe_o_vld = 1'b0;
      if (kv_last_seen) begin
        kv_last_seen = 0;
        lat_cnt = 4;
      end else if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) pe_o_vld = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    q_fires = 0; kv_fires = 0; row_starts = 0;
    writes = 0; done_cnt = 0; kv_split = 0;
    kv_seq.delete();
    addr_seq.delete();
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || done) && n < 3000) begin
      tick();
      n++;
    end
    chk({nm, "_finish"}, (n < 3000) ? 1 : 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n = 0;
    bit ok;
    clr();
    exp_kvl = (v.kl > 64) ? 64 : v.kl;
    q_len = 7'(v.ql);
    kv_len = 7'(v.kl);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (done_cnt == 0 && n < 3000) begin
      tick();
      n++;
      if (v.poke != 0 && n == 20) begin
        q_len = 7'd1; kv_len = 7'd1; start = 1'b1;
      end
      if (n == 21) start = 1'b0;
    end
    tick();
    tick();
    chk({nm, "_done"}, done_cnt, 1);
    chk({nm, "_rowstart"}, row_starts, v.rs);
    chk({nm, "_qfire"}, q_fires, v.qf);
    chk({nm, "_kvfire"}, kv_fires, v.kf);
    chk({nm, "_writes"}, writes, v.wr);
    chk({nm, "_kvsplit"}, kv_split, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_stall"}, stall_cnt, 0);
    ok = 1;
    foreach (kv_seq[i]) if (kv_seq[i] != i % exp_kvl) ok = 0;
    chk({nm, "_kvidx_seq"}, ok, 1);
    ok = 1;
    foreach (addr_seq[i]) if (addr_seq[i] != i) ok = 0;
    chk({nm, "_addr_seq"}, ok, 1);
  endtask

  initial begin
    int k0, n;
    vt[0] = '{2, 3, 0, 2, 2, 6, 2};
    vt[1] = '{2, 0, 0, 0, 0, 0, 0};
    vt[2] = '{0, 5, 0, 0, 0, 0, 0};
    vt[3] = '{1, 1, 0, 1, 1, 1, 1};
    vt[4] = '{3, 2, 0, 3, 3, 6, 3};
    vt[5] = '{100, 1, 1, 64, 64, 64, 64};
    vt[6] = '{1, 100, 0, 1, 1, 64, 1};

    rst = 1'b0; start = 1'b0; q_len = '0; kv_len = '0;
    q_src_vld = 1'b1; kv_src_vld = 1'b1;
    pe_q_rdy = 1'b1; pe_k_rdy = 1'b1; pe_v_rdy = 1'b1;
    pe_o_vld = 1'b0; o_sram_rdy = 1'b1;
    clr();
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_qidx", q_idx, 0);
    chk("rst_kvidx", kv_idx, 0);
    chk("rst_rowstart", pe_row_start, 0);
    chk("rst_qvld", pe_q_vld, 0);
    chk("rst_kvrdy", kv_src_rdy, 0);
    chk("rst_stall", stall_cnt, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Start latency and zero-length timing
    exp_kvl = 1;
    q_len = 7'd1; kv_len = 7'd1; start = 1'b1;
    @(negedge clk); #1;
    chk("lat_t_rowstart", pe_row_start, 0);
    tick(); start = 1'b0;
    @(negedge clk); #1;
    chk("lat_t1_rowstart", pe_row_start, 1);
    chk("lat_t1_busy", busy, 1);
    tick();
    @(negedge clk); #1;
    chk("lat_t2_qvld", pe_q_vld, 1);
    chk("lat_t2_qrdy", q_src_rdy, 1);
    wait_idle("lat");

    clr();
    tick();
    q_len = 7'd2; kv_len = 7'd0; start = 1'b1;
    @(negedge clk); #1;
    chk("zl_t_busy", busy, 0);
    tick(); start = 1'b0;
    @(negedge clk); #1;
    chk("zl_t1_done", done, 0);
    chk("zl_t1_busy", busy, 1);
    tick();
    @(negedge clk); #1;
    chk("zl_t2_done", done, 1);
    chk("zl_t2_busy", busy, 1);
    tick();
    @(negedge clk); #1;
    chk("zl_t3_done", done, 0);
    chk("zl_t3_busy", busy, 0);
    chk("zl_traffic", row_starts + q_fires + kv_fires, 0);

    // Backpressure on V for 5 cycles
    clr();
    exp_kvl = 4;
    tick();
    q_len = 7'd1; kv_len = 7'd4; start = 1'b1;
    tick(); start = 1'b0;
    n = 0;
    while (kv_fires < 2 && n < 50) begin tick(); n++; end
    chk("bp_reach", kv_fires, 2);
    pe_v_rdy = 1'b0;
    k0 = kv_fires;
    @(negedge clk); #1;
    chk("bp_kvrdy", kv_src_rdy, 0);
    chk("bp_kvld", pe_k_vld, 1);
    repeat (4) tick();
    tick();
    pe_v_rdy = 1'b1;
    chk("bp_nofire", kv_fires, k0);
    chk("bp_kvidx", kv_idx, 2);
    wait_idle("bp");
    chk("bp_kvtotal", kv_fires, 4);
    chk("bp_stall", stall_cnt, EXP_STALL);

    // Protocol error during LOAD_Q
    clr();
    auto_o = 0;
    exp_kvl = 1;
    q_src_vld = 1'b0;
    tick();
    q_len = 7'd1; kv_len = 7'd1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    pe_o_vld = 1'b1;
    @(negedge clk); #1;
    chk("pe_wren", o_wr_en, 0);
    chk("pe_qvld_gate", pe_q_vld, 0);
    tick();
    pe_o_vld = 1'b0;
    chk("pe_err_set", err, 1);
    q_src_vld = 1'b1;
    auto_o = 1;
    wait_idle("pe_job");
    chk("pe_err_sticky", err, 1);
    chk("pe_writes", writes, 1);
    tick();
    start = 1'b1;
    tick(); start = 1'b0;
    chk("pe_err_clr", err, 0);
    wait_idle("pe_job2");

    // Reset in STREAM_KV at kv_idx=1, then a full restart
    clr();
    exp_kvl = 3;
    tick();
    q_len = 7'd2; kv_len = 7'd3; start = 1'b1;
    tick(); start = 1'b0;
    n = 0;
    while (kv_fires < 1 && n < 50) begin tick(); n++; end
    chk("mr_kvidx", kv_idx, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mr_busy", busy, 0);
    chk("mr_kvidx0", kv_idx, 0);
    chk("mr_qidx0", q_idx, 0);
    chk("mr_kvld", pe_k_vld, 0);
    chk("mr_kvrdy", kv_src_rdy, 0);
    chk("mr_wren", o_wr_en, 0);
    chk("mr_done", done, 0);
    tick();
    run_vec(vt[0], "mr_rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
